key_frame_rx: RTL and testbench
===============================

# key_frame_rx

Serial key-ingest receiver for the cold wallet: the receiving end of the byte-wise UART key transfer the wallet uses to emit its 256-bit key. It samples one UART line (8N1, LSB first), assembles NUM_BYTES consecutive bytes into a key word, and presents the word with a one-cycle valid pulse. Partial frames are discarded on framing errors, inter-byte gaps or zeroize, so a truncated key never reaches the AES or ROM side.

## Interface
- CLKS_PER_BIT, 87, clock cycles per UART bit; must be ≥ 8.
- NUM_BYTES, 32, bytes per key frame; key width is 8*NUM_BYTES.
- GAP_BITS, 20, maximum idle between completed bytes of one frame, in bit times.
- clk_i  in  1  system clock; the block's only clock.
- rst_i  in  1  asynchronous, active-low reset.
- rx_serial_i  in  1  UART line, asynchronous to clk_i, idle high.
- clear_i  in  1  synchronous zeroize: clears key_o and aborts any partial frame.
- key_o  out  8*NUM_BYTES  last complete key; byte i at key_o[i*8+:8], where byte 0 is the first byte received.
- key_valid_o  out  1  one-cycle pulse when key_o is updated.
- frame_err_o  out  1  one-cycle pulse when a partial frame is aborted.
- busy_o  out  1  high while byte count > 0 or the byte receiver is not IDLE.

## Operation
- Input synchroniser: two flops on rx_serial_i, both reset to 1. All sampling uses the synchronised line.
- Byte receiver FSM, states IDLE, START, DATA, STOP, with counter clk_cnt and bit index bit_idx:
  - IDLE: line low -> START, clk_cnt=0.
  - START: at clk_cnt=(CLKS_PER_BIT-1)/2 (integer division), line still low -> DATA with clk_cnt=0; line high -> IDLE (glitch, no error).
  - DATA: at clk_cnt=CLKS_PER_BIT-1, shift the sample into data bit bit_idx (LSB first) and reset clk_cnt. After bit 7 -> STOP.
  - STOP: at clk_cnt=CLKS_PER_BIT-1, a high sample pulses byte_valid; a low sample pulses byte_err. Either way -> IDLE.
- Frame assembler:
  - byte_cnt runs 0..NUM_BYTES-1. Each byte_valid writes slot byte_cnt of the staging register.
  - When the last slot is written: copy staging to key_o, pulse key_valid_o, byte_cnt=0.
  - key_o holds its value until the next complete frame, clear_i, or reset.
- Gap timer:
  - Runs only while byte_cnt > 0 and reloads on every byte_valid.
  - Reaching GAP_BITS*CLKS_PER_BIT aborts the frame: byte_cnt=0, frame_err_o pulses.
  - A byte in flight at expiry is kept and becomes byte 0 of a new frame.
- Abort conditions (byte_err, gap timeout, clear_i): byte_cnt=0 and staging is zeroed. frame_err_o pulses for byte_err and timeout only, and only if byte_cnt > 0 or the aborting event is byte_err.
- clear_i sets key_o to 0 and does not pulse key_valid_o.

## Timing
- Reset values:
  - key_o=0, key_valid_o=0, frame_err_o=0, busy_o=0.
  - FSM in IDLE, byte_cnt=0, synchroniser flops=1.
- Start-edge to STOP sample: 2 (sync) + (CLKS_PER_BIT-1)/2 + 9*CLKS_PER_BIT + 1 cycles.
- byte_valid and byte_err are registered and appear 1 cycle after the STOP sample.
- key_valid_o appears 1 cycle after the final byte_valid, in the same cycle key_o changes.
- Simultaneous events, priority:
  - clear_i beats byte_valid; a byte completing in the same cycle is dropped.
  - byte_valid beats gap-timer expiry; the frame continues.
  - A final byte_valid coincident with clear_i produces no key_valid_o.
- Back-to-back bytes with zero idle between stop and next start are supported, since STOP returns to IDLE at mid-stop-bit.
- Reset asserted mid-frame: every output goes to its reset value immediately (asynchronous); the partial frame is lost.

## Structure
- Package cw_uart_pkg holds the rx state enum (IDLE, START, DATA, STOP) and the UART_DATA_BITS=8 constant.
- Sub-module cw_uart_byte_rx contains the synchroniser and the byte FSM, and outputs byte, byte_valid and byte_err.
- key_frame_rx contains the assembler, gap timer, zeroize logic and output registers.

## Test plan
- Send 32 bytes 0x00..0x1F back to back -> exactly one key_valid_o pulse; key_o[7:0]=0x00, key_o[255:248]=0x1F; frame_err_o never asserts.
- Send 5 good bytes, then a 6th with the stop bit forced low -> one frame_err_o pulse, no key_valid_o; a following 32×0xA5 frame -> key_o all 0xA5.
- Send 10 bytes, then idle 20*87+10 clocks -> frame_err_o pulses once near expiry and busy_o drops; a following full frame is accepted intact.
- Drive a 20-clock low glitch on an idle line -> no byte, no frame_err_o, busy_o high only during START.
- Load a frame of 0x5A; assert rst_i low mid-way through the next frame -> key_o=0 while in reset; after release a full 0x3C frame -> key_o all 0x3C.
- After a valid frame, pulse clear_i -> key_o=0 the next cycle with no key_valid_o; clear_i in the same cycle as the final byte_valid -> no key_valid_o and key_o=0.

Source files
------------

// File: rtl/cw_uart_pkg.sv
// rtl/cw_uart_pkg.sv - shared UART receive types and constants
package cw_uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/cw_uart_byte_rx.sv
// rtl/cw_uart_byte_rx.sv - 8N1 byte receiver with input synchroniser
module cw_uart_byte_rx
  import cw_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      rx_serial_i,
  output logic [UART_DATA_BITS-1:0] byte_o,
  output logic                      byte_valid_o,
  output logic                      byte_err_o,
  output logic                      busy_o
);

  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int IDX_W  = $clog2(UART_DATA_BITS);
  localparam int HALF   = (CLKS_PER_BIT - 1) / 2;

  rx_state_e                 state;
  logic                      rx_meta;
  logic                      rx_sync;
  logic [CNT_W-1:0]          clk_cnt;
  logic [IDX_W-1:0]          bit_idx;
  logic [UART_DATA_BITS-1:0] shift;

  assign busy_o = (state != IDLE);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rx_meta      <= 1'b1;
      rx_sync      <= 1'b1;
      state        <= IDLE;
      clk_cnt      <= '0;
      bit_idx      <= '0;
      shift        <= '0;
      byte_o       <= '0;
      byte_valid_o <= 1'b0;
      byte_err_o   <= 1'b0;
    end else begin
      rx_meta      <= rx_serial_i;
      rx_sync      <= rx_meta;
      byte_valid_o <= 1'b0;
      byte_err_o   <= 1'b0;
      case (state)
        IDLE: begin
          clk_cnt <= '0;
          bit_idx <= '0;
          if (!rx_sync) state <= START;
        end
        START: begin
          // a start bit that is high again at its midpoint is treated as noise
          if (clk_cnt == CNT_W'(HALF)) begin
            clk_cnt <= '0;
            state   <= rx_sync ? IDLE : DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        DATA: begin
          if (clk_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
            clk_cnt        <= '0;
            shift[bit_idx] <= rx_sync;
            if (bit_idx == IDX_W'(UART_DATA_BITS - 1)) begin
              bit_idx <= '0;
              state   <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        STOP: begin
          // leaves at mid-stop-bit so a back-to-back start edge is not missed
          if (clk_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
            clk_cnt      <= '0;
            byte_o       <= shift;
            byte_valid_o <= rx_sync;
            byte_err_o   <= ~rx_sync;
            state        <= IDLE;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/key_frame_rx.sv
// rtl/key_frame_rx.sv - assembles UART bytes into a key word with gap timeout and zeroize
module key_frame_rx
  import cw_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int NUM_BYTES    = 32,
  parameter int GAP_BITS     = 20
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   rx_serial_i,
  input  logic                   clear_i,
  output logic [8*NUM_BYTES-1:0] key_o,
  output logic                   key_valid_o,
  output logic                   frame_err_o,
  output logic                   busy_o
);

  localparam int CNT_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int GAP_LIMIT = GAP_BITS * CLKS_PER_BIT;
  localparam int GAP_W     = $clog2(GAP_LIMIT);

  logic [UART_DATA_BITS-1:0] rx_byte;
  logic                      rx_valid;
  logic                      rx_err;
  logic                      rx_busy;
  logic [CNT_W-1:0]          byte_cnt;
  logic [GAP_W-1:0]          gap_cnt;
  logic [8*NUM_BYTES-1:0]    stage;
  logic [8*NUM_BYTES-1:0]    stage_next;
  logic                      last_slot;
  logic                      gap_hit;

  cw_uart_byte_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_rx (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .rx_serial_i (rx_serial_i),
    .byte_o      (rx_byte),
    .byte_valid_o(rx_valid),
    .byte_err_o  (rx_err),
    .busy_o      (rx_busy)
  );

  always_comb begin
    stage_next = stage;
    stage_next[{byte_cnt, 3'b000} +: 8] = rx_byte;
  end

  assign last_slot = (byte_cnt == CNT_W'(NUM_BYTES - 1));
  assign gap_hit   = (byte_cnt != '0) && (gap_cnt == GAP_W'(GAP_LIMIT - 1));
  assign busy_o    = (byte_cnt != '0) || rx_busy;

  // priority: zeroize, then receive error, then new byte, then gap timeout
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      key_o       <= '0;
      key_valid_o <= 1'b0;
      frame_err_o <= 1'b0;
      stage       <= '0;
      byte_cnt    <= '0;
      gap_cnt     <= '0;
    end else begin
      key_valid_o <= 1'b0;
      frame_err_o <= 1'b0;
      if (clear_i) begin
        key_o    <= '0;
        stage    <= '0;
        byte_cnt <= '0;
        gap_cnt  <= '0;
      end else if (rx_err) begin
        stage       <= '0;
        byte_cnt    <= '0;
        gap_cnt     <= '0;
        frame_err_o <= 1'b1;
      end else if (rx_valid) begin
        gap_cnt <= '0;
        if (last_slot) begin
          key_o       <= stage_next;
          key_valid_o <= 1'b1;
          stage       <= '0;
          byte_cnt    <= '0;
        end else begin
          stage    <= stage_next;
          byte_cnt <= byte_cnt + 1'b1;
        end
      end else if (gap_hit) begin
        stage       <= '0;
        byte_cnt    <= '0;
        gap_cnt     <= '0;
        frame_err_o <= 1'b1;
      end else if (byte_cnt != '0) begin
        gap_cnt <= gap_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_key_frame_rx.sv
// tb/tb_key_frame_rx.sv - self-checking bench for key_frame_rx
module tb_key_frame_rx;

  localparam int CPB = 8;
  localparam int NB  = 32;
  localparam int GAP = 20;
  localparam int KW  = 8 * NB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx = 1'b1;
  logic          clear = 1'b0;
  logic [KW-1:0] key;
  logic          key_valid;
  logic          frame_err;
  logic          busy;

  key_frame_rx #(
    .CLKS_PER_BIT(CPB),
    .NUM_BYTES   (NB),
    .GAP_BITS    (GAP)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_n),
    .rx_serial_i(rx),
    .clear_i    (clear),
    .key_o      (key),
    .key_valid_o(key_valid),
    .frame_err_o(frame_err),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int key_cnt  = 0;
  int err_cnt  = 0;
  bit busy_seen = 1'b0;
  logic [KW-1:0] exp_q[$];

  task automatic check(input string name, input logic [KW-1:0] act, input logic [KW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (busy) busy_seen = 1'b1;
    if (frame_err === 1'b1) err_cnt++;
    if (key_valid === 1'b1) begin
      key_cnt++;
      if (exp_q.size() == 0) check("unexpected_key_valid", 1, 0);
      else check("key_scoreboard", key, exp_q.pop_front());
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit good_stop, input bit clr_stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = good_stop;
    if (clr_stop) clear = 1'b1;
    repeat (CPB) @(negedge clk);
    if (clr_stop) begin
      repeat (4) @(negedge clk);
      clear = 1'b0;
    end
    rx = 1'b1;
  endtask

  typedef struct {
    int         nbytes;
    logic [7:0] base;
    logic [7:0] step;
    int         bad_idx;
    int         idle;
    int         exp_keys;
    int         exp_errs;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int k0, e0;
    logic [KW-1:0] ek;

    vecs[0] = '{NB, 8'h00, 8'h01, -1, 2*CPB,       1, 0};
    vecs[1] = '{6,  8'h10, 8'h01,  5, 4*CPB,       0, 1};
    vecs[2] = '{NB, 8'hA5, 8'h00, -1, 2*CPB,       1, 0};
    vecs[3] = '{10, 8'h40, 8'h01, -1, GAP*CPB+10,  0, 1};
    vecs[4] = '{NB, 8'h80, 8'h03, -1, 2*CPB,       1, 0};

    repeat (3) @(negedge clk);
    check("reset_key", key, '0);
    check("reset_key_valid", KW'(key_valid), 0);
    check("reset_frame_err", KW'(frame_err), 0);
    check("reset_busy", KW'(busy), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      k0 = key_cnt;
      e0 = err_cnt;
      if (vecs[v].nbytes == NB && vecs[v].bad_idx < 0) begin
        ek = '0;
        for (int i = 0; i < NB; i++) ek[i*8 +: 8] = vecs[v].base + 8'(i) * vecs[v].step;
        exp_q.push_back(ek);
      end
      for (int i = 0; i < vecs[v].nbytes; i++)
        send_byte(vecs[v].base + 8'(i) * vecs[v].step, i != vecs[v].bad_idx, 1'b0);
      repeat (vecs[v].idle) @(negedge clk);
      #1;
      check($sformatf("v%0d_keys", v), KW'(key_cnt - k0), KW'(vecs[v].exp_keys));
      check($sformatf("v%0d_errs", v), KW'(err_cnt - e0), KW'(vecs[v].exp_errs));
      check($sformatf("v%0d_busy", v), KW'(busy), 0);
      if (v == 0) begin
        check("v0_first_byte", KW'(key[7:0]), KW'(8'h00));
        check("v0_last_byte", KW'(key[KW-1 -: 8]), KW'(8'h1F));
      end
    end

    // short low glitch on an idle line
    k0 = key_cnt; e0 = err_cnt; busy_seen = 1'b0;
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (4*CPB) @(negedge clk);
    #1;
    check("glitch_busy_seen", KW'(busy_seen), 1);
    check("glitch_busy_end", KW'(busy), 0);
    check("glitch_errs", KW'(err_cnt - e0), 0);
    check("glitch_keys", KW'(key_cnt - k0), 0);

    // 0x5A frame, then reset in the middle of the next frame
    ek = {NB{8'h5A}};
    exp_q.push_back(ek);
    for (int i = 0; i < NB; i++) send_byte(8'h5A, 1'b1, 1'b0);
    repeat (2*CPB) @(negedge clk);
    check("frame_5a", key, ek);
    for (int i = 0; i < 12; i++) send_byte(8'h3C, 1'b1, 1'b0);
    rx = 1'b0;
    repeat (4*CPB) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_key", key, '0);
    check("async_reset_busy", KW'(busy), 0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    ek = {NB{8'h3C}};
    exp_q.push_back(ek);
    for (int i = 0; i < NB; i++) send_byte(8'h3C, 1'b1, 1'b0);
    repeat (2*CPB) @(negedge clk);
    check("frame_3c", key, ek);

    // zeroize after a good frame
    k0 = key_cnt;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clear_key", key, '0);
    check("clear_no_key_valid", KW'(key_cnt - k0), 0);

    // zeroize coinciding with the final byte
    k0 = key_cnt; e0 = err_cnt;
    for (int i = 0; i < NB - 1; i++) send_byte(8'(i), 1'b1, 1'b0);
    send_byte(8'hFF, 1'b1, 1'b1);
    repeat (2*CPB) @(negedge clk);
    #1;
    check("clear_final_keys", KW'(key_cnt - k0), 0);
    check("clear_final_key", key, '0);
    check("clear_final_errs", KW'(err_cnt - e0), 0);
    check("clear_final_busy", KW'(busy), 0);
    check("scoreboard_drained", KW'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
